// File: rtl/md5_pkg.sv
// md5_pkg: shared constants and state encoding for the md5 match unit.
// Contents: state_t (IDLE/ARMED/FOUND), MD5_MSG_BITS, MD5_HASH_BITS.
package md5_pkg;
    localparam int MD5_MSG_BITS = 152;
    localparam int MD5_HASH_BITS = 128;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FOUND = 2'd2
    } state_t;
endpackage

// File: rtl/md5_match_unit_if.sv
// md5_match_unit_if: host strobes, md5core digest stream and match results.
// master drives en/target/arm/clear and the digest stream (a/b/c/d/m/valid),
// slave (the match unit) returns armed/match_found/match_msg and, with
// MD5_MATCH_COUNT_EN defined, hash_count.
interface md5_match_unit_if
    import md5_pkg::*;
#(
    parameter int MSG_BITS = MD5_MSG_BITS
);
    logic                     en;
    logic                     target_load;
    logic [MD5_HASH_BITS-1:0] target_in;
    logic                     arm;
    logic                     clear;
    logic [31:0]              a_in;
    logic [31:0]              b_in;
    logic [31:0]              c_in;
    logic [31:0]              d_in;
    logic [MSG_BITS-1:0]      m_in;
    logic                     valid_in;
    logic                     armed;
    logic                     match_found;
    logic [MSG_BITS-1:0]      match_msg;
`ifdef MD5_MATCH_COUNT_EN
    logic [31:0]              hash_count;
`endif
    modport master (
        output en, target_load, target_in, arm, clear,
        output a_in, b_in, c_in, d_in, m_in, valid_in,
`ifdef MD5_MATCH_COUNT_EN
        input  hash_count,
`endif
        input  armed, match_found, match_msg
    );
    modport slave (
        input  en, target_load, target_in, arm, clear,
        input  a_in, b_in, c_in, d_in, m_in, valid_in,
`ifdef MD5_MATCH_COUNT_EN
        output hash_count,
`endif
        output armed, match_found, match_msg
    );
endinterface

// File: rtl/md5_match_cmp.sv
// md5_match_cmp: stage 1, registers the digest-vs-target compare as two 64-bit halves.
// Ports: clk_12mhz, reset, en (hold when low), accept (capture), flush (drop v1),
// a_in..d_in/m_in digest and message, target; outputs v1, eq_hi, eq_lo, m1.
module md5_match_cmp
    import md5_pkg::*;
#(
    parameter int MSG_BITS = MD5_MSG_BITS
) (
    input  logic                     clk_12mhz,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     accept,
    input  logic                     flush,
    input  logic [31:0]              a_in,
    input  logic [31:0]              b_in,
    input  logic [31:0]              c_in,
    input  logic [31:0]              d_in,
    input  logic [MSG_BITS-1:0]      m_in,
    input  logic [MD5_HASH_BITS-1:0] target,
    output logic                     v1,
    output logic                     eq_hi,
    output logic                     eq_lo,
    output logic [MSG_BITS-1:0]      m1
);
    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            v1    <= 1'b0;
            eq_hi <= 1'b0;
            eq_lo <= 1'b0;
            m1    <= '0;
        end else if (en) begin
            v1 <= accept && !flush;
            if (accept) begin
                eq_hi <= {a_in, b_in} == target[127:64];
                eq_lo <= {c_in, d_in} == target[63:0];
                m1    <= m_in;
            end
        end
    end
endmodule

// File: rtl/md5_match_unit.sv
// md5_match_unit: compares md5core digests against a host target, latches the first hit.
// Ports: clk_12mhz, reset (sync, active-high), bus (md5_match_unit_if.slave).
// Optional: define MD5_MATCH_COUNT_EN for the saturating hash_count register.
module md5_match_unit
    import md5_pkg::*;
#(
    parameter int MSG_BITS = MD5_MSG_BITS
) (
    input  logic             clk_12mhz,
    input  logic             reset,
    md5_match_unit_if.slave  bus
);
    state_t                     state, state_next;
    logic [MD5_HASH_BITS-1:0]   target;
    logic                       v1, eq_hi, eq_lo;
    logic [MSG_BITS-1:0]        m1;
    logic                       accept, hit, drop;
    logic                       match_found;
    logic [MSG_BITS-1:0]        match_msg;

    assign accept = bus.en && bus.valid_in && state == ARMED;
    assign hit    = v1 && eq_hi && eq_lo && state == ARMED;
    assign drop   = bus.target_load || bus.clear;

    md5_match_cmp #(.MSG_BITS(MSG_BITS)) cmp (
        .clk_12mhz(clk_12mhz),
        .reset(reset),
        .en(bus.en),
        .accept(accept),
        .flush(drop || hit),
        .a_in(bus.a_in),
        .b_in(bus.b_in),
        .c_in(bus.c_in),
        .d_in(bus.d_in),
        .m_in(bus.m_in),
        .target(target),
        .v1(v1),
        .eq_hi(eq_hi),
        .eq_lo(eq_lo),
        .m1(m1)
    );

    always_comb begin
        state_next = drop                         ? IDLE  :
                     hit                          ? FOUND :
                     (bus.arm && state == IDLE)   ? ARMED : state;
    end

    always_ff @(posedge clk_12mhz) begin
        if (reset) begin
            state       <= IDLE;
            target      <= '0;
            match_found <= 1'b0;
            match_msg   <= '0;
        end else if (bus.en) begin
            state <= state_next;
            if (bus.target_load)
                target <= bus.target_in;
            if (drop) begin
                match_found <= 1'b0;
                match_msg   <= '0;
            end else if (hit) begin
                match_found <= 1'b1;
                match_msg   <= m1;
            end
        end
    end

`ifdef MD5_MATCH_COUNT_EN
    logic [31:0] hash_count;
    always_ff @(posedge clk_12mhz) begin
        if (reset)
            hash_count <= '0;
        else if (bus.en) begin
            if (state == IDLE && state_next == ARMED)
                hash_count <= '0;
            else if (accept && hash_count != 32'hFFFF_FFFF)
                hash_count <= hash_count + 32'd1;
        end
    end
    assign bus.hash_count = hash_count;
`endif

    assign bus.armed       = state == ARMED;
    assign bus.match_found = match_found;
    assign bus.match_msg   = match_msg;
endmodule

// File: tb/tb_md5_match_unit.sv
// tb_md5_match_unit: directed self-checking bench for md5_match_unit.
module tb_md5_match_unit;
    import md5_pkg::*;

    localparam logic [127:0] T_FOX = 128'ha2004f37_730b9445_670a738f_a0fc9ee5;
    localparam logic [127:0] T_HEL = 128'hac98cf84_ae657376_cea165e6_729ddb39;
    localparam logic [127:0] T_TIS = 128'hcaea4868_5020e1b5_11a454f6_60943eaa;
    localparam logic [127:0] T_NONE = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [151:0] M_FOX = 152'h54686520_71756963_6b206272_6f776e20_666f78;
    localparam logic [151:0] M_HEL = 152'h48656c6c_6f20576f_726c6420_31323334_353637;
    localparam logic [151:0] M_TIS = 152'h54686973_20697320_61207465_73742e20_313233;

    logic clk_12mhz = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;

    md5_match_unit_if #(.MSG_BITS(152)) bus ();

    md5_match_unit #(.MSG_BITS(152)) dut (
        .clk_12mhz(clk_12mhz),
        .reset(reset),
        .bus(bus)
    );

    always #40 clk_12mhz = ~clk_12mhz;

    task automatic tick();
        @(posedge clk_12mhz);
        #1;
    endtask

    task automatic bus_idle();
        bus.en = 1'b1;
        bus.target_load = 1'b0;
        bus.target_in = '0;
        bus.arm = 1'b0;
        bus.clear = 1'b0;
        {bus.a_in, bus.b_in, bus.c_in, bus.d_in} = '0;
        bus.m_in = '0;
        bus.valid_in = 1'b0;
    endtask

    task automatic load_target(input logic [127:0] t);
        bus.target_load = 1'b1;
        bus.target_in = t;
        tick();
        bus.target_load = 1'b0;
    endtask

    task automatic do_arm();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask

    task automatic present(input logic [127:0] dg, input logic [151:0] m);
        {bus.a_in, bus.b_in, bus.c_in, bus.d_in} = dg;
        bus.m_in = m;
        bus.valid_in = 1'b1;
    endtask

    task automatic feed(input logic [127:0] dg, input logic [151:0] m);
        present(dg, m);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_idle();
        tick();
        tick();
        reset = 1'b0;
        total++;
        if (bus.armed !== 1'b0) begin bad++; $display("FAIL reset_armed got=%0b exp=0", bus.armed); end
        total++;
        if (bus.match_found !== 1'b0) begin bad++; $display("FAIL reset_found got=%0b exp=0", bus.match_found); end
        total++;
        if (bus.match_msg !== '0) begin bad++; $display("FAIL reset_msg got=%h exp=0", bus.match_msg); end
`ifdef MD5_MATCH_COUNT_EN
        total++;
        if (bus.hash_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.hash_count); end
`endif
    endtask

    task automatic test_first_match();
        load_target(T_FOX);
        do_arm();
        total++;
        if (bus.armed !== 1'b1) begin bad++; $display("FAIL t1_armed got=%0b exp=1", bus.armed); end
        feed(T_FOX, M_FOX);
        total++;
        if (bus.match_found !== 1'b0) begin bad++; $display("FAIL t1_early got=%0b exp=0", bus.match_found); end
        feed(T_HEL, M_HEL);
        total++;
        if (bus.match_found !== 1'b1) begin bad++; $display("FAIL t1_found got=%0b exp=1", bus.match_found); end
        total++;
        if (bus.armed !== 1'b0) begin bad++; $display("FAIL t1_armed_drop got=%0b exp=0", bus.armed); end
        feed(T_TIS, M_TIS);
        bus.valid_in = 1'b0;
        tick();
        total++;
        if (bus.match_msg !== M_FOX) begin bad++; $display("FAIL t1_msg got=%h exp=%h", bus.match_msg, M_FOX); end
`ifdef MD5_MATCH_COUNT_EN
        total++;
        if (bus.hash_count !== 32'd2) begin bad++; $display("FAIL t1_count got=%0d exp=2", bus.hash_count); end
`endif
        do_arm();
        total++;
        if (bus.armed !== 1'b0 || bus.match_found !== 1'b1) begin
            bad++; $display("FAIL t1_arm_in_found armed=%0b found=%0b exp armed=0 found=1", bus.armed, bus.match_found);
        end
    endtask

    task automatic test_last_match();
        load_target(T_TIS);
        total++;
        if (bus.match_found !== 1'b0 || bus.match_msg !== '0) begin
            bad++; $display("FAIL t2_load_clears found=%0b msg=%h exp found=0 msg=0", bus.match_found, bus.match_msg);
        end
        do_arm();
        feed(T_FOX, M_FOX);
        feed(T_HEL, M_HEL);
        feed(T_TIS, M_TIS);
        bus.valid_in = 1'b0;
        total++;
        if (bus.match_found !== 1'b0) begin bad++; $display("FAIL t2_early got=%0b exp=0", bus.match_found); end
        tick();
        total++;
        if (bus.match_found !== 1'b1) begin bad++; $display("FAIL t2_found got=%0b exp=1", bus.match_found); end
        total++;
        if (bus.match_msg !== M_TIS) begin bad++; $display("FAIL t2_msg got=%h exp=%h", bus.match_msg, M_TIS); end
`ifdef MD5_MATCH_COUNT_EN
        total++;
        if (bus.hash_count !== 32'd3) begin bad++; $display("FAIL t2_count got=%0d exp=3", bus.hash_count); end
`endif
    endtask

    task automatic test_no_match();
        load_target(T_NONE);
        do_arm();
        for (int i = 0; i < 5; i++)
            feed(i % 3 == 0 ? T_FOX : i % 3 == 1 ? T_HEL : T_TIS, M_HEL);
        bus.valid_in = 1'b0;
        tick();
        tick();
        total++;
        if (bus.match_found !== 1'b0) begin bad++; $display("FAIL t3_found got=%0b exp=0", bus.match_found); end
        total++;
        if (bus.armed !== 1'b1) begin bad++; $display("FAIL t3_armed got=%0b exp=1", bus.armed); end
`ifdef MD5_MATCH_COUNT_EN
        total++;
        if (bus.hash_count !== 32'd5) begin bad++; $display("FAIL t3_count got=%0d exp=5", bus.hash_count); end
`endif
    endtask

    task automatic test_arm_coincident();
        load_target(T_HEL);
        present(T_HEL, M_HEL);
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
`ifdef MD5_MATCH_COUNT_EN
        total++;
        if (bus.hash_count !== 32'd0) begin bad++; $display("FAIL t4_count0 got=%0d exp=0", bus.hash_count); end
`endif
        tick();
        bus.valid_in = 1'b0;
        total++;
        if (bus.match_found !== 1'b0) begin bad++; $display("FAIL t4_not_accepted got=%0b exp=0", bus.match_found); end
        tick();
        total++;
        if (bus.match_found !== 1'b1 || bus.match_msg !== M_HEL) begin
            bad++; $display("FAIL t4_later found=%0b msg=%h exp found=1 msg=%h", bus.match_found, bus.match_msg, M_HEL);
        end
    endtask

    task automatic test_clear_hit();
        load_target(T_HEL);
        do_arm();
        feed(T_HEL, M_HEL);
        bus.valid_in = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        total++;
        if (bus.match_found !== 1'b0 || bus.armed !== 1'b0) begin
            bad++; $display("FAIL t5_clear found=%0b armed=%0b exp 0/0", bus.match_found, bus.armed);
        end
        tick();
        total++;
        if (bus.match_found !== 1'b0) begin bad++; $display("FAIL t5_flushed got=%0b exp=0", bus.match_found); end
        do_arm();
        feed(T_HEL, M_HEL);
        bus.valid_in = 1'b0;
        tick();
        total++;
        if (bus.match_found !== 1'b1 || bus.match_msg !== M_HEL) begin
            bad++; $display("FAIL t5_rearm found=%0b msg=%h exp found=1 msg=%h", bus.match_found, bus.match_msg, M_HEL);
        end
    endtask

    task automatic test_en_stall_reset();
        load_target(T_FOX);
        do_arm();
        feed(T_FOX, M_FOX);
        bus.valid_in = 1'b0;
        bus.en = 1'b0;
        bus.clear = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.match_found !== 1'b0 || bus.armed !== 1'b1) begin
                bad++; $display("FAIL t6_stall%0d found=%0b armed=%0b exp 0/1", i, bus.match_found, bus.armed);
            end
        end
        bus.clear = 1'b0;
        bus.en = 1'b1;
        tick();
        total++;
        if (bus.match_found !== 1'b1 || bus.match_msg !== M_FOX) begin
            bad++; $display("FAIL t6_resume found=%0b msg=%h exp found=1 msg=%h", bus.match_found, bus.match_msg, M_FOX);
        end
        load_target(T_HEL);
        do_arm();
        feed(T_HEL, M_HEL);
        bus.valid_in = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (bus.match_found !== 1'b0 || bus.armed !== 1'b0 || bus.match_msg !== '0) begin
            bad++; $display("FAIL t6_reset found=%0b armed=%0b msg=%h exp all 0", bus.match_found, bus.armed, bus.match_msg);
        end
`ifdef MD5_MATCH_COUNT_EN
        total++;
        if (bus.hash_count !== 32'd0) begin bad++; $display("FAIL t6_reset_count got=%0d exp=0", bus.hash_count); end
`endif
        tick();
        total++;
        if (bus.match_found !== 1'b0) begin bad++; $display("FAIL t6_post_reset got=%0b exp=0", bus.match_found); end
    endtask

    initial begin
        test_reset();
        test_first_match();
        test_last_match();
        test_no_match();
        test_arm_coincident();
        test_clear_hit();
        test_en_stall_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/md5_match_unit.md
# md5_match_unit

Downstream consumer of the pipelined `md5core`. It takes each finished digest (`a`/`b`/`c`/`d`) together with the 19-byte candidate message that travelled alongside it, and compares the digest against a host-loaded 128-bit target hash. It latches the first matching message and raises a sticky match flag for the host interface to read back. It optionally counts the digests it has examined.

## Interface

Parameters:
- `MSG_BITS`, default 152: width of the candidate message carried beside the digest.

Ports:
- `clk_12mhz` in, 1: system clock.
- `reset` in, 1: synchronous, active-high.
- `en` in, 1: pipeline advance enable, same meaning as in `md5core`; when low, all state holds.
- `target_load` in, 1: one-cycle strobe that latches `target_in`.
- `target_in` in, 128: target digest as {A,B,C,D}, each word in the same word/byte order as the `md5core` outputs.
- `arm` in, 1: one-cycle strobe that starts a search.
- `clear` in, 1: one-cycle strobe that drops the match and returns to IDLE.
- `a_in`, `b_in`, `c_in`, `d_in` in, 32 each: digest words from `md5core`.
- `m_in` in, MSG_BITS: candidate message from `md5core` (`m_out`).
- `valid_in` in, 1: digest/message valid (`md5core` `valid_out`).
- `armed` out, 1: state == ARMED.
- `match_found` out, 1: sticky match flag.
- `match_msg` out, MSG_BITS: message that produced the match.
- `hash_count` out, 32: digests examined since `arm`. Present only with `MD5_MATCH_COUNT_EN`.

## Operation

- States:
  - IDLE (reset state).
  - ARMED.
  - FOUND.
- Transitions:
  - IDLE → ARMED on `arm`.
  - ARMED → FOUND on a stage-2 hit.
  - Any state → IDLE on `clear` or `target_load`.
  - `arm` in ARMED or FOUND is ignored.
- Target register:
  - Loads on `target_load` in any state.
  - Reset value 0.
  - `target_load` also clears `match_found` and `match_msg`.
- Accept rule: a digest is accepted when `en && valid_in && state==ARMED` at the clock edge. This is evaluated using the pre-edge state, so `valid_in` coincident with `arm` is not accepted.
- Stage 1 (registered):
  - Captures `v1`, `m1`.
  - Captures `eq_hi = ({a_in,b_in} == target[127:64])` and `eq_lo = ({c_in,d_in} == target[63:0])`.
  - The 128-bit compare is split into these two halves for timing.
- Stage 2:
  - If `v1 && eq_hi && eq_lo` and state==ARMED: set `match_found` = 1, set `match_msg` = `m1`, and go to FOUND.
  - In FOUND, further hits are ignored, so the first match wins.
  - Pipeline contents at the ARMED→FOUND transition are discarded.
- Priority at one edge: `reset` > `target_load` > `clear` > stage-2 hit > `arm`.
  - A hit coincident with `clear` is dropped.
  - Stage-1 contents are flushed (`v1` = 0) on `clear`, `target_load`, and IDLE entry.
- Reset values:
  - `armed` = 0, `match_found` = 0, `match_msg` = 0, `hash_count` = 0.
  - Target = 0, `v1` = 0, state = IDLE.
- `en` low freezes stage 1, stage 2, state and counter. Strobes are ignored while `en` is low.

## Timing

- Latency: digest accepted at edge N → `match_found` high and `match_msg` valid after edge N+1, visible in the cycle after N+1.
- Throughput: one digest per cycle, back-to-back `valid_in` supported with no bubbles.
- `match_found` stays high until `clear`, `target_load` or `reset`.
- `armed` falls on the same edge that sets `match_found`.
- `hash_count`:
  - Increments at the accept edge.
  - Cleared to 0 on `arm` (IDLE→ARMED).
  - Holds in FOUND and IDLE.
  - Saturates at 0xFFFF_FFFF with no wrap.

## Configuration

- `MD5_MATCH_COUNT_EN` defined:
  - 32-bit saturating `hash_count` register and port are present.
  - The host uses it for rate measurement.
- Not defined:
  - The `hash_count` port and logic are absent.
  - All other behaviour is identical.

## Structure

- Shared package/include `md5_pkg`:
  - State encoding constants (IDLE=2'd0, ARMED=2'd1, FOUND=2'd2).
  - `MD5_MSG_BITS` = 152.
  - `MD5_HASH_BITS` = 128.
- One natural sub-module, `md5_match_cmp`: registered split 64-bit compare (stage 1), instantiated once.
- Everything else stays flat in `md5_match_unit`.

## Test plan

1. Load target a2004f37_730b9445_670a738f_a0fc9ee5, `arm`, then feed the digest/message pairs below on consecutive cycles:
   - "The quick brown fox" (54686520_…_666f78) with its digest.
   - "Hello World 1234567" with digest ac98cf84_ae657376_cea165e6_729ddb39.
   - "This is a test. 123" with digest caea4868_5020e1b5_11a454f6_60943eaa.

   Required response: `match_found` = 1 exactly 2 edges after the first pair, `match_msg` = 54686520_71756963_6b206272_6f776e20_666f78, `armed` = 0, and `hash_count` = 2 (count freezes in FOUND; the third pair is not counted).
2. Target = caea4868_…_60943eaa, same three-digest stream. Required response: `match_found` rises 2 edges after the third digest, `match_msg` = "This is a test. 123", `hash_count` = 3.
3. No-match stream of 5 digests → `match_found` stays 0, `armed` stays 1, `hash_count` = 5.
4. A matching digest presented on the same edge as `arm` is not accepted: no match and `hash_count` = 0. The same digest presented one cycle later matches.
5. `clear` asserted on the edge the stage-2 hit would land → `match_found` stays 0 and state = IDLE. A later `arm` plus the same digest matches normally.
6. `en` = 0 for 3 cycles between accept and stage 2 → `match_found` is delayed by exactly 3 cycles. Synchronous `reset` mid-search → all outputs 0 and state = IDLE on the next edge.
